gol_vga_render: RTL and testbench

Display stage downstream of the Game of Life core: consumes the packed `board` array and drives a 640x480@60 Hz VGA DAC interface (8-bit R/G/B, sync, blank, pixel clock). A board snapshot is captured once per frame at the start of vertical blanking, so a generation step mid-frame never tears the picture. Only interior cells (rows 1..HEIGHT-2, cols 1..WIDTH-2) are drawn; the halo ring is never displayed.

---
 rtl/gol_vga_render.sv | 184 ++++++++++++++++++
 tb/tb_gol_vga_render.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_vga_render.sv
// Scans a Game of Life board out to a 640x480@60 VGA DAC, snapshotting the board at the start of vblank.
// Define GOL_VGA_GRID_EN to draw 202020 grid lines on the last pixel row/column of every cell.
module gol_vga_render #(
  parameter int HEIGHT  = 20,
  parameter int WIDTH   = 20,
  parameter int CELL_PX = 16,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [0:HEIGHT-1][0:WIDTH-1]  board,
  output logic [7:0]                    r,
  output logic [7:0]                    g,
  output logic [7:0]                    b,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          vga_blank,
  output logic                          vga_sync,
  output logic                          vga_clk,
  output logic                          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int PW    = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [PW-1:0] PX_LAST  = PW'(CELL_PX - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 3);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 3);

  logic                         pix_en_q, vga_clk_q;
  logic [HW-1:0]                h_q, h_d;
  logic [VW-1:0]                v_q, v_d;
  logic [PW-1:0]                xpix_q, xpix_d, ypix_q, ypix_d;
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic                         x_in_q, x_in_d, y_in_q, y_in_d;
  logic [0:HEIGHT-1][0:WIDTH-1] snap_q;
  logic [7:0]                   rgb_q, rgb_d;
  logic                         hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic                         visible_s, in_grid_s, live_s, snap_tick_s;

  // Scan counters; cell sub-counters track hcount/vcount and freeze once past the grid edge.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    xpix_d = xpix_q;
    ypix_d = ypix_q;
    col_d  = col_q;
    row_d  = row_q;
    x_in_d = x_in_q;
    y_in_d = y_in_q;
    if (h_q == H_LAST) begin
      h_d    = '0;
      xpix_d = '0;
      col_d  = '0;
      x_in_d = 1'b1;
      if (v_q == V_LAST) begin
        v_d    = '0;
        ypix_d = '0;
        row_d  = '0;
        y_in_d = 1'b1;
      end else begin
        v_d = v_q + VW'(1);
        if ((v_q < V_VIS_L) && y_in_q) begin
          if (ypix_q == PX_LAST) begin
            ypix_d = '0;
            if (row_q == ROW_LAST) y_in_d = 1'b0;
            else                   row_d  = row_q + RW'(1);
          end else begin
            ypix_d = ypix_q + PW'(1);
          end
        end else begin
          ypix_d = ypix_q;
        end
      end
    end else begin
      h_d = h_q + HW'(1);
      if ((h_q < H_VIS_L) && x_in_q) begin
        if (xpix_q == PX_LAST) begin
          xpix_d = '0;
          if (col_q == COL_LAST) x_in_d = 1'b0;
          else                   col_d  = col_q + CW'(1);
        end else begin
          xpix_d = xpix_q + PW'(1);
        end
      end else begin
        xpix_d = xpix_q;
      end
    end
  end

  // Pixel colour and sync levels for the counter position currently held.
  always_comb begin
    visible_s   = (h_q < H_VIS_L) && (v_q < V_VIS_L);
    in_grid_s   = x_in_q && y_in_q;
    live_s      = snap_q[row_q + RW'(1)][col_q + CW'(1)];
    snap_tick_s = (h_q == '0) && (v_q == V_VIS_L);
    rgb_d       = 8'h00;
    if (!visible_s)      rgb_d = 8'h00;
    else if (!in_grid_s) rgb_d = 8'h40;
`ifdef GOL_VGA_GRID_EN
    else if ((xpix_q == PX_LAST) || (ypix_q == PX_LAST)) rgb_d = 8'h20;
`endif
    else if (live_s)     rgb_d = 8'hFF;
    else                 rgb_d = 8'h00;
    hs_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
    blank_d = visible_s;
    fs_d    = (h_q == '0) && (v_q == '0);
  end

  // All state advances on pixel ticks only; frame_start is cleared on the off-tick clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      xpix_q    <= '0;
      ypix_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      x_in_q    <= 1'b1;
      y_in_q    <= 1'b1;
      snap_q    <= '0;
      rgb_q     <= 8'h00;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      vga_clk_q <= pix_en_q;
      fs_q      <= 1'b0;
      if (pix_en_q) begin
        h_q     <= h_d;
        v_q     <= v_d;
        xpix_q  <= xpix_d;
        ypix_q  <= ypix_d;
        col_q   <= col_d;
        row_q   <= row_d;
        x_in_q  <= x_in_d;
        y_in_q  <= y_in_d;
        rgb_q   <= rgb_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= blank_d;
        fs_q    <= fs_d;
        if (snap_tick_s) snap_q <= board;
      end
    end
  end

  assign r           = rgb_q;
  assign g           = rgb_q;
  assign b           = rgb_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign vga_blank   = blank_q;
  assign vga_sync    = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_gol_vga_render.sv
// Self-checking bench: a shrunken-timing instance checked pixel-by-pixel against a behavioural
// model, plus a default-parameter instance checked over its first two lines.
module tb_gol_vga_render;

  localparam int S_H = 6, S_W = 8, S_CPX = 8;
  localparam int S_HV = 56, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VV = 40, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
  localparam logic [29:0] RST_VEC = {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [0:S_H-1][0:S_W-1] board_s = '0;
  logic [0:S_H-1][0:S_W-1] msnap = '0;
  logic [0:19][0:19] board_f = '0;
  logic [7:0] r_s, g_s, b_s, r_f, g_f, b_f;
  logic hs_s, vs_s, bl_s, sy_s, vc_s, fs_s;
  logic hs_f, vs_f, bl_f, sy_f, vc_f, fs_f;
  int edge_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_fs_s = -1;

  always #5 clk = ~clk;

  gol_vga_render #(
    .HEIGHT(S_H), .WIDTH(S_W), .CELL_PX(S_CPX),
    .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .clk(clk), .reset(reset), .board(board_s),
    .r(r_s), .g(g_s), .b(b_s),
    .hsync_out(hs_s), .vsync_out(vs_s), .vga_blank(bl_s),
    .vga_sync(sy_s), .vga_clk(vc_s), .frame_start(fs_s)
  );

  gol_vga_render u_full (
    .clk(clk), .reset(reset), .board(board_f),
    .r(r_f), .g(g_f), .b(b_f),
    .hsync_out(hs_f), .vsync_out(vs_f), .vga_blank(bl_f),
    .vga_sync(sy_f), .vga_clk(vc_f), .frame_start(fs_f)
  );

  // Reference model: outputs seen just after the e-th clk edge since reset release.
  function automatic logic [29:0] small_exp(input int e);
    int k, h, v, cc, cr;
    logic [7:0] c;
    logic vis;
    if (e < 2) return RST_VEC;
    k = e / 2 - 1;
    h = k % S_HT;
    v = (k / S_HT) % S_VT;
    vis = (h < S_HV) && (v < S_VV);
    cc = h / S_CPX;
    cr = v / S_CPX;
    if (!vis) c = 8'h00;
    else if (cc >= S_W - 2 || cr >= S_H - 2) c = 8'h40;
`ifdef GOL_VGA_GRID_EN
    else if (h % S_CPX == S_CPX - 1 || v % S_CPX == S_CPX - 1) c = 8'h20;
`endif
    else if (msnap[cr + 1][cc + 1]) c = 8'hFF;
    else c = 8'h00;
    return {c, c, c,
            !(h >= S_HV + S_HF && h < S_HV + S_HF + S_HS),
            !(v >= S_VV + S_VF && v < S_VV + S_VF + S_VS),
            vis, 1'b0, (e % 2 == 0), (e % 2 == 0) && h == 0 && v == 0};
  endfunction

  // Advance one clk edge; the model snapshot follows the board on the capture tick.
  task automatic step();
    int en, k;
    en = edge_n + 1;
    if (en % 2 == 0) begin
      k = en / 2 - 1;
      if (k % S_HT == 0 && (k / S_HT) % S_VT == S_VV) msnap = board_s;
    end
    @(posedge clk);
    #1;
    edge_n = en;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_small clk=%0d actual=%h expected=%h", i,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, RST_VEC);
      end
      n_cmp++;
      if ({r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f} !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_full clk=%0d actual=%h expected=%h", i,
                 {r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f}, RST_VEC);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    msnap = '0;
    last_fs_s = -1;
  endtask

  task automatic test_default_line();
    int k, h, v, low0, low1;
    logic [7:0] c;
    logic vis;
    logic [29:0] exp_f;
    low0 = 0;
    low1 = 0;
    for (int e = 1; e <= 3201; e++) begin
      step();
      if (edge_n < 2) exp_f = RST_VEC;
      else begin
        k = edge_n / 2 - 1;
        h = k % 800;
        v = k / 800;
        vis = (h < 640) && (v < 480);
        c = !vis ? 8'h00 : (h >= 288 ? 8'h40 : 8'h00);
`ifdef GOL_VGA_GRID_EN
        if (vis && h < 288 && (h % 16 == 15 || v % 16 == 15)) c = 8'h20;
`endif
        exp_f = {c, c, c, !(h >= 656 && h < 752), 1'b1, vis, 1'b0,
                 (edge_n % 2 == 0), (edge_n == 2)};
      end
      n_cmp++;
      if ({r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f} !== exp_f) begin
        n_bad++;
        $display("FAIL default_line e=%0d actual=%h expected=%h", edge_n,
                 {r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f}, exp_f);
      end
      if (edge_n >= 2 && edge_n <= 1601 && hs_f === 1'b0) low0++;
      if (edge_n >= 1602 && edge_n <= 3201 && hs_f === 1'b0) low1++;
      if (fs_s === 1'b1) begin
        n_cmp++;
        if (edge_n != 2) begin
          n_bad++;
          $display("FAIL first_frame_start actual_edge=%0d expected_edge=2", edge_n);
        end
        last_fs_s = edge_n;
      end
    end
    n_cmp++;
    if (low0 != 192 || low1 != 192) begin
      n_bad++;
      $display("FAIL hsync_width actual=%0d/%0d clk expected=192/192 clk", low0, low1);
    end
  endtask

  task automatic test_single_cell();
    int k, h, v, f, pulses;
    int px[6] = '{3, 7, 8, 50, 0, 20};
    int py[6] = '{3, 3, 0, 0, 35, 20};
    logic [7:0] pc[6];
    logic [29:0] exp_s;
    pc[0] = 8'hFF;
`ifdef GOL_VGA_GRID_EN
    pc[1] = 8'h20;
`else
    pc[1] = 8'hFF;
`endif
    pc[2] = 8'h00;
    pc[3] = 8'h40;
    pc[4] = 8'h40;
    pc[5] = 8'h00;
    pulses = 0;
    board_s = '0;
    board_s[1][1] = 1'b1;
    while (edge_n < 4 * S_FRAME + 2) begin
      step();
      exp_s = small_exp(edge_n);
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== exp_s) begin
        n_bad++;
        $display("FAIL stream_single e=%0d actual=%h expected=%h", edge_n,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, exp_s);
      end
      if (fs_s === 1'b1) begin
        pulses++;
        n_cmp++;
        if (last_fs_s < 0 || edge_n - last_fs_s != 2 * S_FRAME) begin
          n_bad++;
          $display("FAIL frame_period actual=%0d clk expected=%0d clk", edge_n - last_fs_s, 2 * S_FRAME);
        end
        last_fs_s = edge_n;
      end
      if (edge_n % 2 == 0) begin
        k = edge_n / 2 - 1;
        f = k / S_FRAME;
        h = k % S_HT;
        v = (k / S_HT) % S_VT;
        for (int p = 0; p < 6; p++) begin
          if (f == 1 && h == px[p] && v == py[p]) begin
            n_cmp++;
            if (r_s !== pc[p]) begin
              n_bad++;
              $display("FAIL cell_pixel x=%0d y=%0d actual=%h expected=%h", px[p], py[p], r_s, pc[p]);
            end
          end
        end
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL frame_pulses actual=%0d expected=2", pulses);
    end
  endtask

  task automatic test_glider_change();
    int k, h, v, f;
    bit changed;
    logic [29:0] exp_s;
    changed = 1'b0;
    board_s = '0;
    board_s[1][2] = 1'b1;
    board_s[2][3] = 1'b1;
    board_s[3][1] = 1'b1;
    board_s[3][2] = 1'b1;
    board_s[3][3] = 1'b1;
    while (edge_n < 2 * (4 * S_FRAME + S_VV * S_HT) + 2) begin
      step();
      exp_s = small_exp(edge_n);
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== exp_s) begin
        n_bad++;
        $display("FAIL stream_glider e=%0d actual=%h expected=%h", edge_n,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, exp_s);
      end
      if (edge_n % 2 == 0) begin
        k = edge_n / 2 - 1;
        f = k / S_FRAME;
        h = k % S_HT;
        v = (k / S_HT) % S_VT;
        if (f == 3 && v == 20 && h == 0 && !changed) begin
          for (int i = 0; i < S_H; i++)
            for (int j = 0; j < S_W; j++)
              board_s[i][j] = 1'($urandom_range(0, 1));
          board_s[4][1] = 1'b1;
          changed = 1'b1;
        end
        if (f == 3 && h == 10 && v == 2) begin
          n_cmp++;
          if (r_s !== 8'hFF) begin
            n_bad++;
            $display("FAIL glider_live actual=%h expected=ff", r_s);
          end
        end
        if ((f == 3 || f == 4) && h == 4 && v == 28) begin
          n_cmp++;
          if (r_s !== (f == 3 ? 8'h00 : 8'hFF)) begin
            n_bad++;
            $display("FAIL board_change frame=%0d actual=%h expected=%h", f, r_s, (f == 3 ? 8'h00 : 8'hFF));
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int k, h, v, f, guard;
    bit found;
    logic [29:0] exp_s;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 2 * S_FRAME) begin
      step();
      guard++;
      exp_s = small_exp(edge_n);
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== exp_s) begin
        n_bad++;
        $display("FAIL stream_pre_reset e=%0d actual=%h expected=%h", edge_n,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, exp_s);
      end
      k = edge_n / 2 - 1;
      if (edge_n % 2 == 0 && (k / S_HT) % S_VT == 20 && k % S_HT == 5) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL mid_reset_reach actual=not_reached expected=line20");
    end
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== RST_VEC) begin
        n_bad++;
        $display("FAIL mid_reset_small step=%0d actual=%h expected=%h", i,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, RST_VEC);
      end
      n_cmp++;
      if ({r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f} !== RST_VEC) begin
        n_bad++;
        $display("FAIL mid_reset_full step=%0d actual=%h expected=%h", i,
                 {r_f, g_f, b_f, hs_f, vs_f, bl_f, sy_f, vc_f, fs_f}, RST_VEC);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    msnap = '0;
    while (edge_n < 2 * (S_FRAME + S_VV * S_HT) + 2) begin
      step();
      exp_s = small_exp(edge_n);
      n_cmp++;
      if ({r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s} !== exp_s) begin
        n_bad++;
        $display("FAIL stream_post_reset e=%0d actual=%h expected=%h", edge_n,
                 {r_s, g_s, b_s, hs_s, vs_s, bl_s, sy_s, vc_s, fs_s}, exp_s);
      end
      if (edge_n % 2 == 0) begin
        k = edge_n / 2 - 1;
        f = k / S_FRAME;
        h = k % S_HT;
        v = (k / S_HT) % S_VT;
        if (h == 0 && v == 0 && f == 0) begin
          n_cmp++;
          if (fs_s !== 1'b1 || edge_n != 2) begin
            n_bad++;
            $display("FAIL restart_frame_start actual=%b@%0d expected=1@2", fs_s, edge_n);
          end
        end
        if ((f == 0 || f == 1) && h == 4 && v == 28) begin
          n_cmp++;
          if (r_s !== (f == 0 ? 8'h00 : 8'hFF)) begin
            n_bad++;
            $display("FAIL snap_cleared frame=%0d actual=%h expected=%h", f, r_s, (f == 0 ? 8'h00 : 8'hFF));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_single_cell();
    test_glider_change();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
